// File: rtl/alu_pkg.sv
// Shared definitions for the 16-bit ALU datapath.
//   ALU_W        datapath width (fixed at 16)
//   alu_word_t   one datapath word
//   alu_flags_t  condition codes {C, N, Z, V}
//   fa_sum       single-bit sum function shared by the ripple and lookahead adders
package alu_pkg;

   localparam int unsigned ALU_W = 16;

   typedef logic [ALU_W-1:0] alu_word_t;

   typedef struct packed {
      logic C;
      logic N;
      logic Z;
      logic V;
   } alu_flags_t;

   function automatic logic fa_sum(input logic a, input logic b, input logic ci);
      return a ^ b ^ ci;
   endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder used as the ripple-chain stage.
//   a, b  operand bits
//   ci    carry in
//   s     sum bit
//   co    carry out
module full_adder
   import alu_pkg::*;
(
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = fa_sum(a, b, ci);
   assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/sixteen_bit_alu.sv
// Registered 16-bit adder with carry-in and C/N/Z/V condition codes.
//   clk       rising-edge clock
//   rst       asynchronous active-high reset; clears sum and all flags (Z too)
//   cin       carry into bit 0
//   A, B      operands
//   sum       registered (A + B + cin) mod 2^16
//   C,N,Z,V   registered carry, negative, zero and signed-overflow flags
// Build option: define ALU_CLA_EN for a 4x4-bit carry-lookahead adder; otherwise
// a 16-stage ripple chain of full_adder cells is used. Both give identical results.
module sixteen_bit_alu
   import alu_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             cin,
   input  logic [ALU_W-1:0] A,
   input  logic [ALU_W-1:0] B,
   output logic [ALU_W-1:0] sum,
   output logic             C,
   output logic             N,
   output logic             Z,
   output logic             V
);

   alu_word_t  sum_d, sum_q;
   alu_flags_t flags_d, flags_q;
   logic       carry_out;

`ifdef ALU_CLA_EN
   logic [ALU_W-1:0] g, p;
   logic [ALU_W-1:0] c;
   logic [3:0]       gg, gp;
   logic [4:0]       gc;

   always_comb begin
      g  = A & B;
      p  = A ^ B;
      gg = '0;
      gp = '0;
      for (int j = 0; j < 4; j++) begin
         gg[j] = g[4*j+3]
               | (p[4*j+3] & g[4*j+2])
               | (p[4*j+3] & p[4*j+2] & g[4*j+1])
               | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
         gp[j] = &p[4*j +: 4];
      end

      // Lookahead carry unit: group carries straight from group G/P and cin.
      gc[0] = cin;
      gc[1] = gg[0] | (gp[0] & gc[0]);
      gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & gc[0]);
      gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
            | (gp[2] & gp[1] & gp[0] & gc[0]);
      gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
            | (gp[3] & gp[2] & gp[1] & gg[0])
            | (gp[3] & gp[2] & gp[1] & gp[0] & gc[0]);

      // Bit carries inside each group, looked ahead from the group carry-in.
      c = '0;
      for (int j = 0; j < 4; j++) begin
         c[4*j]   = gc[j];
         c[4*j+1] = g[4*j] | (p[4*j] & gc[j]);
         c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | (p[4*j+1] & p[4*j] & gc[j]);
         c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1]) | (p[4*j+2] & p[4*j+1] & g[4*j])
                  | (p[4*j+2] & p[4*j+1] & p[4*j] & gc[j]);
      end

      sum_d = '0;
      for (int k = 0; k < ALU_W; k++) begin
         sum_d[k] = fa_sum(A[k], B[k], c[k]);
      end
      carry_out = gc[4];
   end
`else
   logic [ALU_W:0] carry;

   assign carry[0] = cin;

   for (genvar i = 0; i < ALU_W; i++) begin : g_ripple
      full_adder u_fa (
         .a  (A[i]),
         .b  (B[i]),
         .ci (carry[i]),
         .s  (sum_d[i]),
         .co (carry[i+1])
      );
   end

   assign carry_out = carry[ALU_W];
`endif

   always_comb begin
      flags_d   = '0;
      flags_d.C = carry_out;
      flags_d.N = sum_d[ALU_W-1];
      flags_d.Z = ~|sum_d;
      // Overflow: like-signed operands producing a result of the other sign.
      flags_d.V = (A[ALU_W-1] == B[ALU_W-1]) && (sum_d[ALU_W-1] != A[ALU_W-1]);
   end

   // Z clears on reset to mean "no result yet", even though sum reads zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum_q   <= '0;
         flags_q <= '0;
      end else begin
         sum_q   <= sum_d;
         flags_q <= flags_d;
      end
   end

   assign sum = sum_q;
   assign C   = flags_q.C;
   assign N   = flags_q.N;
   assign Z   = flags_q.Z;
   assign V   = flags_q.V;

endmodule

// File: tb/tb_sixteen_bit_alu.sv
// Self-checking bench for sixteen_bit_alu: directed vector table, reset
// sequences and randomized operands against an arithmetic reference model.
module tb_sixteen_bit_alu;

   logic        clk;
   logic        rst;
   logic        cin;
   logic [15:0] A;
   logic [15:0] B;
   logic [15:0] sum;
   logic        C, N, Z, V;

   int checks = 0;
   int errors = 0;

   sixteen_bit_alu dut (
      .clk (clk),
      .rst (rst),
      .cin (cin),
      .A   (A),
      .B   (B),
      .sum (sum),
      .C   (C),
      .N   (N),
      .Z   (Z),
      .V   (V)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        ci;
      logic [15:0] s;
      logic        c;
      logic        n;
      logic        z;
      logic        v;
   } vec_t;

   vec_t vecs[9];

   task automatic check_all(input string name, input logic [15:0] es, input logic ec,
                            input logic en, input logic ez, input logic ev);
      checks++;
      if (sum !== es || C !== ec || N !== en || Z !== ez || V !== ev) begin
         errors++;
         $display("FAIL %s: got sum=%h C=%b N=%b Z=%b V=%b, expected sum=%h C=%b N=%b Z=%b V=%b",
                  name, sum, C, N, Z, V, es, ec, en, ez, ev);
      end
   endtask

   // Reference: plain integer arithmetic, overflow from the signed range.
   task automatic model(input logic [15:0] a, input logic [15:0] b, input logic ci,
                        output logic [15:0] s, output logic c, output logic n,
                        output logic z, output logic v);
      int unsigned t;
      int          st;
      t  = 32'(a) + 32'(b) + 32'(ci);
      st = int'($signed(a)) + int'($signed(b)) + int'({31'd0, ci});
      s  = t[15:0];
      c  = t[16];
      n  = s[15];
      z  = (s == 16'h0000);
      v  = (st > 32767) || (st < -32768);
   endtask

   initial begin
      logic [15:0] es, ps;
      logic        ec, en, ez, ev, pc, pn, pz, pv;

      vecs[0] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[1] = '{16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[2] = '{16'hEEEE, 16'h3333, 1'b0, 16'h2221, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[3] = '{16'h5555, 16'h4444, 1'b1, 16'h999A, 1'b0, 1'b1, 1'b0, 1'b1};
      vecs[4] = '{16'hAAAA, 16'hBBBB, 1'b1, 16'h6666, 1'b1, 1'b0, 1'b0, 1'b1};
      vecs[5] = '{16'hAAAA, 16'hBBBB, 1'b0, 16'h6665, 1'b1, 1'b0, 1'b0, 1'b1};
      vecs[6] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[7] = '{16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1};
      vecs[8] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1};

      // Reset state: everything zero, including Z.
      rst = 1'b1;
      cin = 1'b1;
      A   = 16'h1234;
      B   = 16'h4321;
      repeat (2) @(posedge clk);
      #1 check_all("reset_state", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b0;

      // Directed table, back-to-back; just before each edge the previous
      // result must still be showing (one-cycle latency).
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         A   = vecs[i].a;
         B   = vecs[i].b;
         cin = vecs[i].ci;
         if (i > 0) begin
            #1 check_all($sformatf("latency_hold_%0d", i), vecs[i-1].s, vecs[i-1].c,
                         vecs[i-1].n, vecs[i-1].z, vecs[i-1].v);
         end
         @(posedge clk);
         #1 check_all($sformatf("vec_%0d", i), vecs[i].s, vecs[i].c, vecs[i].n,
                      vecs[i].z, vecs[i].v);
      end

      // Mid-stream reset between edges discards the held result at once.
      @(negedge clk);
      A   = 16'h1234;
      B   = 16'h1111;
      cin = 1'b0;
      @(posedge clk);
      #1 check_all("pre_reset_result", 16'h2345, 1'b0, 1'b0, 1'b0, 1'b0);
      A   = 16'h0FFF;
      B   = 16'h0001;
      #2 rst = 1'b1;
      #1 check_all("async_reset_clears", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1 check_all("reset_holds_over_edge", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      #1 check_all("released_before_edge", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1 check_all("first_result_after_reset", 16'h1000, 1'b0, 1'b0, 1'b0, 1'b0);

      // Randomized operands against the reference model, back-to-back.
      model(A, B, cin, ps, pc, pn, pz, pv);
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         A   = 16'($urandom);
         B   = 16'($urandom);
         cin = 1'($urandom_range(0, 1));
         if (i % 8 == 0) B = 16'(~A);      // steer toward carry/zero boundaries
         if (i % 8 == 4) A = 16'h7FFF ^ 16'($urandom_range(0, 3));
         model(A, B, cin, es, ec, en, ez, ev);
         #1 check_all($sformatf("rand_hold_%0d", i), ps, pc, pn, pz, pv);
         @(posedge clk);
         #1 check_all($sformatf("rand_%0d", i), es, ec, en, ez, ev);
         ps = es; pc = ec; pn = en; pz = ez; pv = ev;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
